// File: rtl/bsg_cas_sort_sequencer.sv
// Block stream sorter: loads els_p words, odd-even transposition sorts them on one shared
// compare-and-swap unit, then drains ascending. Optional macro: BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN.

module bsg_compare_and_swap #(
    parameter int width_p              = 16,
    parameter int t_p                  = width_p-1,
    parameter int b_p                  = 0,
    parameter bit cond_swap_on_equal_p = 1'b0
) (
    input  logic [1:0][width_p-1:0] data_i,
    input  logic                    swap_on_equal_i,
    output logic [1:0][width_p-1:0] data_o,
    output logic                    swapped_o
);
    logic gt, eq;
    always_comb begin
        gt        = data_i[0][t_p:b_p] > data_i[1][t_p:b_p];
        eq        = data_i[0][t_p:b_p] == data_i[1][t_p:b_p];
        swapped_o = gt || (cond_swap_on_equal_p && swap_on_equal_i && eq);
        data_o    = swapped_o ? {data_i[0], data_i[1]} : data_i;
    end
endmodule

module bsg_cas_sort_sequencer #(
    parameter int els_p   = 8,
    parameter int width_p = 16,
    parameter int t_p     = width_p-1,
    parameter int b_p     = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               busy_o,
    output logic [15:0]        swap_cnt_o
);
    localparam int idx_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int pass_w_lp = $clog2(els_p+1);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [width_p-1:0]        mem_q [els_p];
    logic [idx_w_lp-1:0]       wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, pair_q, pair_d, pair_hi;
    logic [pass_w_lp-1:0]      pass_q, pass_d, next_pass;
    logic [15:0]               swap_cnt_q, swap_cnt_d;
    logic                      mem_we, cas_we, last_pair;
    logic [1:0][width_p-1:0]   cas_in, cas_out;
    logic                      cas_swapped;
`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
    logic                      pass_swap_q, pass_swap_d, prev_zero_q, prev_zero_d, cur_zero;
`endif

    assign pair_hi   = pair_q + idx_w_lp'(1);
    assign cas_in[0] = mem_q[pair_q];
    assign cas_in[1] = mem_q[pair_hi];

    bsg_compare_and_swap #(
        .width_p(width_p), .t_p(t_p), .b_p(b_p), .cond_swap_on_equal_p(1'b0)
    ) cas (
        .data_i(cas_in), .swap_on_equal_i(1'b0), .data_o(cas_out), .swapped_o(cas_swapped)
    );

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        pair_d     = pair_q;
        pass_d     = pass_q;
        swap_cnt_d = swap_cnt_q;
        mem_we     = 1'b0;
        cas_we     = 1'b0;
        last_pair  = 1'b0;
        next_pass  = '0;
`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
        pass_swap_d = pass_swap_q;
        prev_zero_d = prev_zero_q;
        cur_zero    = 1'b0;
`endif
        unique case (state_q)
            LOAD: if (v_i) begin
                mem_we = 1'b1;
                if (wr_idx_q == idx_w_lp'(els_p-1)) begin
                    state_d    = SORT;
                    wr_idx_d   = '0;
                    pair_d     = '0;
                    pass_d     = '0;
                    swap_cnt_d = '0;
`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
                    pass_swap_d = 1'b0;
                    prev_zero_d = 1'b0;
`endif
                end else begin
                    wr_idx_d = wr_idx_q + idx_w_lp'(1);
                end
            end
            SORT: begin
                cas_we = 1'b1;
                if (cas_swapped && swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + 16'd1;
                last_pair = (int'(pair_q) + 2 > els_p - 2);
                if (!last_pair) begin
                    pair_d = idx_w_lp'(int'(pair_q) + 2);
`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
                    pass_swap_d = pass_swap_q | cas_swapped;
`endif
                end else begin
                    // with two words every odd pass is empty, so hop straight to the next even pass
                    next_pass = pass_q + pass_w_lp'((els_p == 2) ? 2 : 1);
                    pass_d    = next_pass;
                    pair_d    = '0;
                    pair_d[0] = next_pass[0];
                    if (int'(next_pass) >= els_p) state_d = DRAIN;
`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
                    cur_zero    = !(pass_swap_q | cas_swapped);
                    pass_swap_d = 1'b0;
                    prev_zero_d = cur_zero;
                    if (cur_zero && (prev_zero_q || els_p == 2)) state_d = DRAIN;
`endif
                end
            end
            DRAIN: if (yumi_i) begin
                if (rd_idx_q == idx_w_lp'(els_p-1)) begin
                    state_d  = LOAD;
                    rd_idx_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + idx_w_lp'(1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= LOAD;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            pair_q     <= '0;
            pass_q     <= '0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            pair_q     <= pair_d;
            pass_q     <= pass_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pass_swap_q <= 1'b0;
            prev_zero_q <= 1'b0;
        end else begin
            pass_swap_q <= pass_swap_d;
            prev_zero_q <= prev_zero_d;
        end
    end
`endif

    // storage carries no reset; contents are meaningless until a full block is loaded
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) mem_q[wr_idx_q] <= data_i;
        if (cas_we && !reset_i) begin
            mem_q[pair_q]  <= cas_out[0];
            mem_q[pair_hi] <= cas_out[1];
        end
    end

    assign ready_o    = (state_q == LOAD);
    assign v_o        = (state_q == DRAIN);
    assign busy_o     = (state_q == SORT);
    assign data_o     = mem_q[rd_idx_q];
    assign swap_cnt_o = swap_cnt_q;

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> (state_q == DRAIN))
        else $error("yumi_i asserted outside DRAIN");
`endif
endmodule

// File: tb/tb_bsg_cas_sort_sequencer.sv
// Bench for bsg_cas_sort_sequencer: four configurations share one stimulus path selected by sel;
// expectations come from a stable-sort / inversion-count reference model.
module tb_bsg_cas_sort_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v_drv, y_drv;
    logic [15:0] din;
    int          sel;
    int          checks = 0, errors = 0;

    logic [3:0]  vi, yi, vo, rdy, bsy;
    logic [15:0] dout [4];
    logic [15:0] swc  [4];
    logic [7:0]  d1, d2, d3;
    logic [15:0] m_dout, m_swc;
    logic        m_v, m_rdy, m_busy;

    always_comb begin
        vi = '0; yi = '0;
        for (int k = 0; k < 4; k++) begin
            vi[k] = v_drv && (sel == k);
            yi[k] = y_drv && (sel == k);
        end
    end
    assign dout[1] = {8'h00, d1};
    assign dout[2] = {8'h00, d2};
    assign dout[3] = {8'h00, d3};
    always_comb begin
        m_dout = dout[sel]; m_swc = swc[sel];
        m_v = vo[sel]; m_rdy = rdy[sel]; m_busy = bsy[sel];
    end

    bsg_cas_sort_sequencer #(.els_p(8), .width_p(16)) u0 (
        .clk_i(clk), .reset_i(rst), .data_i(din), .v_i(vi[0]), .ready_o(rdy[0]), .data_o(dout[0]),
        .v_o(vo[0]), .yumi_i(yi[0]), .busy_o(bsy[0]), .swap_cnt_o(swc[0]));
    bsg_cas_sort_sequencer #(.els_p(8), .width_p(8), .t_p(7), .b_p(4)) u1 (
        .clk_i(clk), .reset_i(rst), .data_i(din[7:0]), .v_i(vi[1]), .ready_o(rdy[1]), .data_o(d1),
        .v_o(vo[1]), .yumi_i(yi[1]), .busy_o(bsy[1]), .swap_cnt_o(swc[1]));
    bsg_cas_sort_sequencer #(.els_p(2), .width_p(8), .t_p(5), .b_p(2)) u2 (
        .clk_i(clk), .reset_i(rst), .data_i(din[7:0]), .v_i(vi[2]), .ready_o(rdy[2]), .data_o(d2),
        .v_o(vo[2]), .yumi_i(yi[2]), .busy_o(bsy[2]), .swap_cnt_o(swc[2]));
    bsg_cas_sort_sequencer #(.els_p(5), .width_p(8), .t_p(5), .b_p(2)) u3 (
        .clk_i(clk), .reset_i(rst), .data_i(din[7:0]), .v_i(vi[3]), .ready_o(rdy[3]), .data_o(d3),
        .v_o(vo[3]), .yumi_i(yi[3]), .busy_o(bsy[3]), .swap_cnt_o(swc[3]));

    function automatic int nels(input int s);
        return (s == 2) ? 2 : (s == 3) ? 5 : 8;
    endfunction

    function automatic int keyf(input int s, input logic [15:0] w);
        if (s == 0) return int'(w);
        if (s == 1) return int'(w[7:4]);
        return int'(w[5:2]);
    endfunction

    // Reference: stable ascending order, inversion count, and number of compare cycles.
    task automatic model(input int s, input logic [15:0] w[$], output logic [15:0] srt[$],
                         output int inv, output int cyc);
        logic [15:0] rem[$];
        int n = w.size();
        int a[$];
        int best;
        rem = w; srt = {}; inv = 0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (keyf(s, w[i]) > keyf(s, w[j])) inv++;
        while (rem.size() > 0) begin
            best = 0;
            for (int i = 1; i < rem.size(); i++)
                if (keyf(s, rem[i]) < keyf(s, rem[best])) best = i;
            srt.push_back(rem[best]);
            rem.delete(best);
        end
        cyc = ((n + 1) / 2) * (n / 2) + (n / 2) * ((n - 1) / 2);
`ifdef BSG_CAS_SORT_SEQUENCER_EARLY_EXIT_EN
        begin
            bit prevzero = 0, sw;
            int t;
            for (int i = 0; i < n; i++) a.push_back(keyf(s, w[i]));
            cyc = 0;
            for (int p = 0; p < n; p++) begin
                if ((p % 2) + 1 > n - 1) continue;
                sw = 0;
                for (int i = p % 2; i + 1 < n; i += 2) begin
                    cyc++;
                    if (a[i] > a[i+1]) begin t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1; end
                end
                if (!sw && (prevzero || n == 2)) break;
                prevzero = !sw;
            end
        end
`endif
    endtask

    task automatic load_words(input logic [15:0] w[$], input bit gaps);
        int k = 0;
        while (k < w.size()) begin
            @(negedge clk);
            if (gaps && $urandom_range(3) == 0) v_drv = 1'b0;
            else begin
                checks++;
                if (m_rdy !== 1'b1) begin
                    errors++; $display("FAIL load_ready word %0d: got %b want 1", k, m_rdy);
                end
                v_drv = 1'b1; din = w[k]; k++;
            end
        end
        @(negedge clk);
        v_drv = 1'b0;
    endtask

    task automatic run_block(input logic [15:0] w[$], input bit gaps, input int hold_at, input bit vpulse);
        logic [15:0] exp[$];
        int inv, cyc, cnt, k, hold, guard;
        int n = nels(sel);
        model(sel, w, exp, inv, cyc);
        load_words(w, gaps);
        cnt = 0;
        while (m_busy === 1'b1 && cnt < 500) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt != cyc) begin errors++; $display("FAIL sort_cycles sel %0d: got %0d want %0d", sel, cnt, cyc); end
        checks++;
        if (m_v !== 1'b1) begin errors++; $display("FAIL drain_valid sel %0d: got %b want 1", sel, m_v); end
        checks++;
        if (m_swc !== 16'(inv)) begin errors++; $display("FAIL swap_cnt sel %0d: got %0d want %0d", sel, m_swc, inv); end
        k = 0; hold = 0; guard = 0;
        while (k < n && guard < 1000) begin
            guard++;
            checks++;
            if (m_v !== 1'b1 || m_dout !== exp[k]) begin
                errors++; $display("FAIL drain_word sel %0d idx %0d: got v=%b %h want v=1 %h", sel, k, m_v, m_dout, exp[k]);
            end
            if (k == hold_at && hold < 5) begin
                y_drv = 1'b0; hold++;
                if (vpulse) begin
                    v_drv = 1'b1; din = 16'($urandom);
                    checks++;
                    if (m_rdy !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b want 0", m_rdy); end
                end
            end else if (gaps && $urandom_range(2) == 0) y_drv = 1'b0;
            else begin y_drv = 1'b1; k++; end
            @(negedge clk);
            y_drv = 1'b0; v_drv = 1'b0;
        end
        if (k < n) begin errors++; $display("FAIL drain_timeout sel %0d: drained %0d want %0d", sel, k, n); end
        checks++;
        if (m_rdy !== 1'b1 || m_v !== 1'b0) begin
            errors++; $display("FAIL back_to_load sel %0d: got ready=%b v=%b want 1/0", sel, m_rdy, m_v);
        end
        checks++;
        if (m_swc !== 16'(inv)) begin errors++; $display("FAIL swap_cnt_hold sel %0d: got %0d want %0d", sel, m_swc, inv); end
    endtask

    task automatic test_reset();
        rst = 1'b1; v_drv = 1'b0; y_drv = 1'b0; din = '0; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (rdy[s] !== 1'b1 || vo[s] !== 1'b0 || bsy[s] !== 1'b0 || swc[s] !== 16'd0) begin
                errors++; $display("FAIL reset_state dut %0d: got r=%b v=%b b=%b c=%0d want 1/0/0/0", s, rdy[s], vo[s], bsy[s], swc[s]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reverse();
        sel = 0;
        run_block('{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 1'b0, -1, 1'b0);
    endtask

    task automatic test_sorted();
        sel = 0;
        run_block('{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7}, 1'b0, -1, 1'b0);
    endtask

    task automatic test_stability();
        sel = 1;
        run_block('{16'h31, 16'h12, 16'h32, 16'h11, 16'hF0, 16'hF0, 16'hF0, 16'hF0}, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [15:0] w[$];
        sel = 0;
        for (int i = 0; i < 8; i++) w.push_back(16'($urandom));
        run_block(w, 1'b0, 3, 1'b1);
    endtask

    task automatic test_reset_mid_sort();
        logic [15:0] w[$];
        sel = 0;
        load_words('{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if (m_busy !== 1'b1) begin errors++; $display("FAIL mid_sort_busy: got %b want 1", m_busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_rdy !== 1'b1 || m_v !== 1'b0 || m_busy !== 1'b0 || m_swc !== 16'd0) begin
            errors++; $display("FAIL reset_mid_sort: got r=%b v=%b b=%b c=%0d want 1/0/0/0", m_rdy, m_v, m_busy, m_swc);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) w.push_back(16'($urandom_range(0, 31)));
        run_block(w, 1'b1, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] w[$];
        int map[3] = '{2, 3, 0};
        for (int b = 0; b < 1000; b++) begin
            sel = map[b % 3];
            w = {};
            for (int i = 0; i < nels(sel); i++)
                w.push_back(sel == 0 ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 255)));
            run_block(w, 1'b1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_sorted();
        test_stability();
        test_backpressure();
        test_reset_mid_sort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
